query_hv_builder: RTL and testbench
===================================

Name: query_hv_builder

Overview:
- Upstream neighbour of the associative memory. Accepts bound feature hypervectors one per handshake and bundles them per dimension into saturating counters.
- On the last feature of a sample, thresholds the counters into a binary sparse query HV. Presents it with its label to the associative memory via a start_querying pulse.
- Holds query_hv stable until the next issue, so the AM segment mux can sweep it.
- Accumulation of the next sample overlaps AM processing of the current one.

Parameters:
- HV_DIM, 80, query/feature hypervector width (must equal SEQ_CYCLE_COUNT*DIMS_PER_CC of the AM).
- MAX_FEATURES, 16, maximum features bundled per sample.
- CNT_W, 5, per-dimension counter width (>= clog2(MAX_FEATURES+1)).
- THRESHOLD, 4, minimum count for a dimension to be 1 (legal range 1..2^CNT_W-1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- nrst  in  1  reset: synchronous, active-high (1 = reset), name kept per codebase.
- en  in  1  global enable; 0 freezes all state and forces feat_ready=0 and start_querying=0.
- feat_valid  in  1  feature HV valid.
- feat_ready  out  1  builder can accept a feature.
- feat_hv  in  HV_DIM  bound feature HV.
- feat_last  in  1  feature is the last of its sample.
- sample_label  in  5  true class of sample; sampled on the feat_last handshake.
- sample_last  in  1  sample is the last of the dataset; sampled on the feat_last handshake, ignored otherwise.
- am_ready  in  1  AM FSM idle, can take a new query.
- start_querying  out  1  one-cycle pulse to AM.
- query_hv  out  HV_DIM  binary query HV to AM.
- correct_class  out  5  label aligned with query_hv.
- testing_dataset_finished  out  1  high after the final query issues.
- sample_count  out  11  queries issued, saturating at 2047.

Behaviour:
- Handshake: a feature is accepted when feat_valid && feat_ready && en. Combinational feat_ready = en && (state==ACCUM). The source holds data while feat_valid=1 and feat_ready=0.
- States: ACCUM, THRESH, ISSUE, DONE. Reset state is ACCUM.
- Reset values: all counters, query_hv, pending_hv, correct_class, sample_count, start_querying and testing_dataset_finished are 0.
- Reset wins over all activity mid-operation. A partially accumulated sample is discarded.
- ACCUM: on each accept, cnt[d] <= sat(cnt[d] + feat_hv[d]). Saturate at 2^CNT_W-1; no wrap.
- ACCUM also keeps a feature counter, reset per sample. Once it reaches MAX_FEATURES, further non-last features are accepted but not added.
- An accept with feat_last=1 adds that feature, latches label and last flag, and moves to THRESH.
- THRESH (1 cycle): pending_hv[d] <= (cnt'[d] >= THRESHOLD), where cnt' includes the final feature. All counters clear to 0 and the state moves to ISSUE.
- ISSUE: waits for am_ready=1. On that cycle, register on the same edge:
  - query_hv <= pending_hv
  - correct_class <= pending label
  - start_querying <= 1 for exactly one cycle
  - sample_count <= sat(sample_count+1)
- After ISSUE, go to DONE if the pending last flag is set, else ACCUM.
- Latency: from the feat_last accept edge, start_querying rises 2 cycles later if am_ready=1. Each extra cycle of am_ready=0 adds one.
- query_hv and correct_class change only on an ISSUE edge and are otherwise held.
- DONE: testing_dataset_finished <= 1 and held, feat_ready=0. Exit only via reset.
- en=0 in any state: no accept, no counter update, no transition, start_querying=0. A pending issue waits until en returns.
- A sample with only a feat_last feature (single-feature sample) is legal.

Test Plan:
- Reset with nrst=1 for 2 cycles -> all outputs 0, feat_ready=1 once nrst=0 and en=1.
- THRESHOLD=4, 5 features where dims 0..9 are set in 4 features and dims 10..19 in 3, the fifth with feat_last=1 and label=7, am_ready=1 -> start_querying pulses 2 cycles after last accept. query_hv[9:0] all 1, query_hv[19:10] all 0, correct_class=7, sample_count=1.
- am_ready held 0 for 6 cycles after THRESH -> feat_ready=0 throughout, start_querying delayed exactly 6 cycles, prior query_hv unchanged until the issue edge.
- 40 identical all-ones features (CNT_W=5) -> counters saturate at 31, no wrap, query_hv all 1.
- Two samples, the second with sample_last=1, then feat_valid held high -> two pulses, testing_dataset_finished=1 after the second, feat_ready stays 0, sample_count=2.
- nrst pulsed after 3 of 5 features -> counters cleared, no start_querying, next full sample thresholds without residue from the aborted one.

Source files
------------

// File: rtl/query_hv_builder.sv
// query_hv_builder
//
// Bundles bound feature hypervectors into per-dimension saturating counters.
// On the last feature of a sample, the counters are thresholded into a binary
// query hypervector. That query is then handed to the associative memory
// together with the sample label. The associative memory is free to sweep
// query_hv while the next sample accumulates, because query_hv only changes
// on an issue edge.
//
// Ports:
//   clk                      clock, all logic on the rising edge
//   nrst                     synchronous reset, active high (1 = reset)
//   en                       global enable; 0 freezes all state
//   feat_valid / feat_ready  feature handshake
//   feat_hv                  bound feature hypervector (HV_DIM bits)
//   feat_last                feature closes the current sample
//   sample_label             class of the sample, captured with feat_last
//   sample_last              sample closes the dataset, captured with feat_last
//   am_ready                 associative memory idle, may take a query
//   start_querying           one-cycle pulse announcing a new query
//   query_hv                 binary query hypervector (held between issues)
//   correct_class            label belonging to query_hv
//   testing_dataset_finished set once the final query has issued
//   sample_count             number of issued queries, saturating at 2047

module query_hv_builder #(
    parameter int HV_DIM       = 80,
    parameter int MAX_FEATURES = 16,
    parameter int CNT_W        = 5,
    parameter int THRESHOLD    = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              feat_valid,
    output logic              feat_ready,
    input  logic [HV_DIM-1:0] feat_hv,
    input  logic              feat_last,
    input  logic [4:0]        sample_label,
    input  logic              sample_last,
    input  logic              am_ready,
    output logic              start_querying,
    output logic [HV_DIM-1:0] query_hv,
    output logic [4:0]        correct_class,
    output logic              testing_dataset_finished,
    output logic [10:0]       sample_count
);

    localparam int               FC_W      = $clog2(MAX_FEATURES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] THR       = CNT_W'(THRESHOLD);
    localparam logic [FC_W-1:0]  FEAT_MAX  = FC_W'(MAX_FEATURES);
    localparam logic [10:0]      SCNT_MAX  = '1;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        THRESH = 2'd1,
        ISSUE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [HV_DIM-1:0][CNT_W-1:0] cnt;
    logic [FC_W-1:0]              feat_cnt;
    logic [HV_DIM-1:0]            pending_hv;
    logic [HV_DIM-1:0]            thresh_hv;
    logic [4:0]                   pending_label;
    logic                         pending_last;
    logic                         start_q;
    logic                         finished_q;

    logic accept;
    logic add_feat;
    logic issue_fire;

    // A feature is only added while under the per-sample feature budget;
    // the closing feature is always added so it can never be lost.
    assign accept     = en && feat_valid && (state == ACCUM);
    assign add_feat   = accept && (feat_last || (feat_cnt < FEAT_MAX));
    assign issue_fire = en && (state == ISSUE) && am_ready;

    assign feat_ready               = en && (state == ACCUM);
    assign start_querying           = start_q && en;
    assign testing_dataset_finished = finished_q;

    // State register.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; with en low every state holds.
    always_comb begin
        state_next = state;
        if (en) begin
            case (state)
                ACCUM: begin
                    if (accept && feat_last) begin
                        state_next = THRESH;
                    end
                end
                THRESH: begin
                    state_next = ISSUE;
                end
                ISSUE: begin
                    if (am_ready) begin
                        state_next = pending_last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = ACCUM;
                end
            endcase
        end
    end

    // Per-dimension comparison against the threshold.
    always_comb begin
        thresh_hv = '0;
        for (int d = 0; d < HV_DIM; d++) begin
            thresh_hv[d] = (cnt[d] >= THR);
        end
    end

    // Bundling counters: saturating increment on each added feature,
    // cleared once the sample has been thresholded.
    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt <= '0;
        end else if (en && (state == THRESH)) begin
            cnt <= '0;
        end else if (add_feat) begin
            for (int d = 0; d < HV_DIM; d++) begin
                if (feat_hv[d] && (cnt[d] != CNT_MAX)) begin
                    cnt[d] <= cnt[d] + CNT_W'(1);
                end
            end
        end
    end

    // Feature budget counter, restarted by the closing feature of a sample.
    always_ff @(posedge clk) begin
        if (nrst) begin
            feat_cnt <= '0;
        end else if (accept) begin
            if (feat_last) begin
                feat_cnt <= '0;
            end else if (feat_cnt != FEAT_MAX) begin
                feat_cnt <= feat_cnt + FC_W'(1);
            end
        end
    end

    // Sample metadata captured with the closing feature, and the
    // thresholded query waiting for the associative memory.
    always_ff @(posedge clk) begin
        if (nrst) begin
            pending_label <= '0;
            pending_last  <= 1'b0;
            pending_hv    <= '0;
        end else begin
            if (accept && feat_last) begin
                pending_label <= sample_label;
                pending_last  <= sample_last;
            end
            if (en && (state == THRESH)) begin
                pending_hv <= thresh_hv;
            end
        end
    end

    // Issue registers: query_hv and correct_class move only on an issue
    // edge so the associative memory sees a stable query while sweeping.
    always_ff @(posedge clk) begin
        if (nrst) begin
            query_hv      <= '0;
            correct_class <= '0;
            sample_count  <= '0;
            start_q       <= 1'b0;
            finished_q    <= 1'b0;
        end else begin
            start_q <= issue_fire;
            if (issue_fire) begin
                query_hv      <= pending_hv;
                correct_class <= pending_label;
                if (sample_count != SCNT_MAX) begin
                    sample_count <= sample_count + 11'd1;
                end
                if (pending_last) begin
                    finished_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_query_hv_builder.sv
// tb_query_hv_builder
//
// Directed bench for query_hv_builder. A default-parameter instance covers
// handshake, thresholding, issue latency, back-pressure, reset abort and
// dataset completion. A second instance with THRESHOLD=31 and
// MAX_FEATURES=31 shares the same stimulus. It shows that the counters
// saturate instead of wrapping.

module tb_query_hv_builder;

    localparam int HV_DIM = 80;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic              feat_valid;
    logic              feat_ready;
    logic [HV_DIM-1:0] feat_hv;
    logic              feat_last;
    logic [4:0]        sample_label;
    logic              sample_last;
    logic              am_ready;
    logic              start_querying;
    logic [HV_DIM-1:0] query_hv;
    logic [4:0]        correct_class;
    logic              testing_dataset_finished;
    logic [10:0]       sample_count;

    logic              sat_feat_ready;
    logic              sat_start_querying;
    logic [HV_DIM-1:0] sat_query_hv;
    logic [4:0]        sat_correct_class;
    logic              sat_finished;
    logic [10:0]       sat_sample_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    query_hv_builder #(
        .HV_DIM(HV_DIM), .MAX_FEATURES(16), .CNT_W(5), .THRESHOLD(4)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_hv(feat_hv), .feat_last(feat_last),
        .sample_label(sample_label), .sample_last(sample_last),
        .am_ready(am_ready), .start_querying(start_querying),
        .query_hv(query_hv), .correct_class(correct_class),
        .testing_dataset_finished(testing_dataset_finished),
        .sample_count(sample_count)
    );

    query_hv_builder #(
        .HV_DIM(HV_DIM), .MAX_FEATURES(31), .CNT_W(5), .THRESHOLD(31)
    ) dut_sat (
        .clk(clk), .nrst(nrst), .en(en),
        .feat_valid(feat_valid), .feat_ready(sat_feat_ready),
        .feat_hv(feat_hv), .feat_last(feat_last),
        .sample_label(sample_label), .sample_last(sample_last),
        .am_ready(am_ready), .start_querying(sat_start_querying),
        .query_hv(sat_query_hv), .correct_class(sat_correct_class),
        .testing_dataset_finished(sat_finished),
        .sample_count(sat_sample_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [HV_DIM-1:0] observed,
                               input logic [HV_DIM-1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one feature and waits (bounded) for it to be accepted.
    // Returns one time unit after the accepting clock edge.
    task automatic applyStimulus(input logic [HV_DIM-1:0] hv, input logic last,
                                 input logic [4:0] label, input logic slast);
        logic accepted;
        accepted     = 1'b0;
        feat_valid   = 1'b1;
        feat_hv      = hv;
        feat_last    = last;
        sample_label = label;
        sample_last  = slast;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (feat_ready) accepted = 1'b1;
            tick();
        end
        feat_valid  = 1'b0;
        feat_last   = 1'b0;
        sample_last = 1'b0;
        checkOutput("feat_accept", HV_DIM'(accepted), HV_DIM'(1));
    endtask

    initial begin
        logic [HV_DIM-1:0] p_mid;
        logic [HV_DIM-1:0] p_abort;
        logic [HV_DIM-1:0] p_keep;
        logic [HV_DIM-1:0] ones;

        p_mid   = 80'hFF << 40;
        p_abort = 80'h3FF << 60;
        p_keep  = 80'h3FF << 70;
        ones    = '1;

        nrst = 1'b1; en = 1'b0; feat_valid = 1'b0; feat_hv = '0;
        feat_last = 1'b0; sample_label = '0; sample_last = 1'b0; am_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_start", HV_DIM'(start_querying), '0);
        checkOutput("rst_query", query_hv, '0);
        checkOutput("rst_class", HV_DIM'(correct_class), '0);
        checkOutput("rst_count", HV_DIM'(sample_count), '0);
        checkOutput("rst_finished", HV_DIM'(testing_dataset_finished), '0);
        checkOutput("rst_ready_en0", HV_DIM'(feat_ready), '0);
        nrst = 1'b0;
        en   = 1'b1;
        #1;
        checkOutput("ready_after_rst", HV_DIM'(feat_ready), HV_DIM'(1));

        // Sample 1: dims 0..9 seen 4 times, dims 10..19 three times, 20..29 once.
        applyStimulus(80'hFFFFF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'hFFFFF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'hFFFFF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'h3FF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'h3FF00000, 1'b1, 5'd7, 1'b0);
        checkOutput("s1_thresh_start", HV_DIM'(start_querying), '0);
        checkOutput("s1_thresh_ready", HV_DIM'(feat_ready), '0);
        tick();
        checkOutput("s1_issue_start", HV_DIM'(start_querying), '0);
        tick();
        checkOutput("s1_pulse", HV_DIM'(start_querying), HV_DIM'(1));
        checkOutput("s1_query", query_hv, 80'h3FF);
        checkOutput("s1_class", HV_DIM'(correct_class), HV_DIM'(7));
        checkOutput("s1_count", HV_DIM'(sample_count), HV_DIM'(1));
        tick();
        checkOutput("s1_pulse_end", HV_DIM'(start_querying), '0);
        checkOutput("s1_query_hold", query_hv, 80'h3FF);

        // Sample 2: am_ready low for 6 cycles once the query is pending.
        applyStimulus(p_mid, 1'b0, 5'd0, 1'b0);
        applyStimulus(p_mid, 1'b0, 5'd0, 1'b0);
        applyStimulus(p_mid, 1'b0, 5'd0, 1'b0);
        am_ready = 1'b0;
        applyStimulus(p_mid, 1'b1, 5'd3, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            checkOutput("s2_wait_ready", HV_DIM'(feat_ready), '0);
            checkOutput("s2_wait_start", HV_DIM'(start_querying), '0);
            checkOutput("s2_wait_query", query_hv, 80'h3FF);
            tick();
        end
        am_ready = 1'b1;
        checkOutput("s2_pre_start", HV_DIM'(start_querying), '0);
        tick();
        checkOutput("s2_pulse", HV_DIM'(start_querying), HV_DIM'(1));
        checkOutput("s2_query", query_hv, p_mid);
        checkOutput("s2_class", HV_DIM'(correct_class), HV_DIM'(3));
        checkOutput("s2_count", HV_DIM'(sample_count), HV_DIM'(2));
        tick();
        checkOutput("s2_pulse_end", HV_DIM'(start_querying), '0);

        // Sample 3: 40 all-ones features, counters must saturate not wrap.
        for (int i = 0; i < 39; i++) begin
            applyStimulus(ones, 1'b0, 5'd0, 1'b0);
        end
        applyStimulus(ones, 1'b1, 5'd12, 1'b0);
        tick();
        tick();
        checkOutput("s3_pulse", HV_DIM'(start_querying), HV_DIM'(1));
        checkOutput("s3_query", query_hv, ones);
        checkOutput("s3_class", HV_DIM'(correct_class), HV_DIM'(12));
        checkOutput("s3_count", HV_DIM'(sample_count), HV_DIM'(3));
        checkOutput("s3_sat_query", sat_query_hv, ones);
        checkOutput("s3_sat_class", HV_DIM'(sat_correct_class), HV_DIM'(12));
        tick();

        // Abort: reset after 3 features, then a fresh sample.
        applyStimulus(p_abort, 1'b0, 5'd0, 1'b0);
        applyStimulus(p_abort, 1'b0, 5'd0, 1'b0);
        applyStimulus(p_abort, 1'b0, 5'd0, 1'b0);
        nrst = 1'b1;
        tick();
        nrst = 1'b0;
        checkOutput("abort_start", HV_DIM'(start_querying), '0);
        checkOutput("abort_query", query_hv, '0);
        checkOutput("abort_count", HV_DIM'(sample_count), '0);
        applyStimulus(p_abort | p_keep, 1'b0, 5'd0, 1'b0);
        // en low: features presented must be ignored.
        en         = 1'b0;
        feat_valid = 1'b1;
        feat_hv    = p_abort;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("en0_ready", HV_DIM'(feat_ready), '0);
            tick();
        end
        feat_valid = 1'b0;
        en         = 1'b1;
        applyStimulus(p_keep, 1'b0, 5'd0, 1'b0);
        applyStimulus(p_keep, 1'b0, 5'd0, 1'b0);
        applyStimulus(p_keep, 1'b1, 5'd21, 1'b0);
        tick();
        checkOutput("s4_no_pulse_yet", HV_DIM'(start_querying), '0);
        tick();
        checkOutput("s4_pulse", HV_DIM'(start_querying), HV_DIM'(1));
        checkOutput("s4_query", query_hv, p_keep);
        checkOutput("s4_class", HV_DIM'(correct_class), HV_DIM'(21));
        checkOutput("s4_count", HV_DIM'(sample_count), HV_DIM'(1));
        tick();

        // Two final samples; the second closes the dataset.
        applyStimulus(80'hF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'hF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'hF, 1'b0, 5'd0, 1'b0);
        applyStimulus(80'hF, 1'b1, 5'd1, 1'b0);
        tick();
        tick();
        checkOutput("s5_pulse", HV_DIM'(start_querying), HV_DIM'(1));
        checkOutput("s5_query", query_hv, 80'hF);
        checkOutput("s5_class", HV_DIM'(correct_class), HV_DIM'(1));
        checkOutput("s5_count", HV_DIM'(sample_count), HV_DIM'(2));
        checkOutput("s5_finished", HV_DIM'(testing_dataset_finished), '0);
        applyStimulus(ones, 1'b1, 5'd30, 1'b1);
        tick();
        tick();
        checkOutput("s6_pulse", HV_DIM'(start_querying), HV_DIM'(1));
        checkOutput("s6_query", query_hv, '0);
        checkOutput("s6_class", HV_DIM'(correct_class), HV_DIM'(30));
        checkOutput("s6_count", HV_DIM'(sample_count), HV_DIM'(3));
        checkOutput("s6_finished", HV_DIM'(testing_dataset_finished), HV_DIM'(1));
        feat_valid = 1'b1;
        feat_hv    = ones;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("done_ready", HV_DIM'(feat_ready), '0);
            checkOutput("done_start", HV_DIM'(start_querying), '0);
            checkOutput("done_finished", HV_DIM'(testing_dataset_finished), HV_DIM'(1));
            checkOutput("done_count", HV_DIM'(sample_count), HV_DIM'(3));
        end
        feat_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
